// File: rtl/adder_result_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : adder_result_buffer                                        |
// | Description : Registered output stage for an N-bit adder. Holds up to    |
// |               two {result, flags} entries in a head + skid buffer behind |
// |               a valid/ready handshake. It also keeps sticky flag bits    |
// |               and a saturating count of accepted results.                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// Ports
//   clk          in   1   rising-edge clock
//   rst          in   1   synchronous reset, active-high
//   in_valid     in   1   upstream presents a valid adder result
//   in_ready     out  1   buffer can accept this cycle
//   in_result    in   N   adder sum
//   in_flags     in   4   [0]=zero, [1]=carry, [3:2] reserved
//   out_valid    out  1   buffered entry available
//   out_ready    in   1   downstream accepts the entry
//   out_result   out  N   head entry sum
//   out_flags    out  4   head entry flags
//   clear        in   1   clears sticky_flags and op_count (data kept)
//   sticky_flags out  4   OR of flags accepted since reset/clear
//   op_count     out  CW  entries accepted since reset/clear, saturating
module adder_result_buffer #(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_result,
  input  logic [3:0]    in_flags,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_result,
  output logic [3:0]    out_flags,
  input  logic          clear,
  output logic [3:0]    sticky_flags,
  output logic [CW-1:0] op_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  head_result;
  logic [3:0]    head_flags;
  logic [N-1:0]  skid_result;
  logic [3:0]    skid_flags;
  logic [3:0]    sticky;
  logic [CW-1:0] count;

  logic          push;
  logic          pop;
  logic [3:0]    kept_flags;

  // Reserved flag bits are forced to zero on capture.
  assign kept_flags = in_flags & 4'b0011;

  // in_ready is decoded from registered state only; it is also held low
  // while reset is asserted so nothing is accepted during reset.
  assign in_ready  = (state != TWO) && !rst;
  assign out_valid = (state != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_result   = head_result;
  assign out_flags    = head_flags;
  assign sticky_flags = sticky;
  assign op_count     = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      head_result <= '0;
      head_flags  <= '0;
      skid_result <= '0;
      skid_flags  <= '0;
      sticky      <= '0;
      count       <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head_result <= in_result;
            head_flags  <= kept_flags;
            state       <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            // Head drains and refills in the same cycle.
            head_result <= in_result;
            head_flags  <= kept_flags;
          end else if (push) begin
            skid_result <= in_result;
            skid_flags  <= kept_flags;
            state       <= TWO;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            head_result <= skid_result;
            head_flags  <= skid_flags;
            state       <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase

      // A clear in the same cycle as a transfer restarts the statistics
      // with that entry alone.
      if (clear) begin
        sticky <= push ? kept_flags : 4'b0000;
        count  <= push ? CW'(1) : '0;
      end else if (push) begin
        sticky <= sticky | kept_flags;
        if (count != {CW{1'b1}}) begin
          count <= count + CW'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adder_result_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_adder_result_buffer                                     |
// | Description : Directed self-checking bench for adder_result_buffer.      |
// |               Instance a uses N=4/CW=8, instance b uses CW=2 to reach    |
// |               counter saturation quickly.                                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_adder_result_buffer;

  logic       clk;
  logic       rst;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_clear;
  logic [3:0] a_in_result, a_in_flags, a_out_result, a_out_flags, a_sticky;
  logic [7:0] a_count;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_clear;
  logic [3:0] b_in_result, b_in_flags, b_out_result, b_out_flags, b_sticky;
  logic [1:0] b_count;

  int total;
  int bad;

  adder_result_buffer #(.N(4), .CW(8)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (a_in_valid),
    .in_ready     (a_in_ready),
    .in_result    (a_in_result),
    .in_flags     (a_in_flags),
    .out_valid    (a_out_valid),
    .out_ready    (a_out_ready),
    .out_result   (a_out_result),
    .out_flags    (a_out_flags),
    .clear        (a_clear),
    .sticky_flags (a_sticky),
    .op_count     (a_count)
  );

  adder_result_buffer #(.N(4), .CW(2)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (b_in_valid),
    .in_ready     (b_in_ready),
    .in_result    (b_in_result),
    .in_flags     (b_in_flags),
    .out_valid    (b_out_valid),
    .out_ready    (b_out_ready),
    .out_result   (b_out_result),
    .out_flags    (b_out_flags),
    .clear        (b_clear),
    .sticky_flags (b_sticky),
    .op_count     (b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: inputs set at a negedge are sampled at the next posedge,
  // outputs are checked at the following negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic a_drive(input logic v, input logic [3:0] r, input logic [3:0] f);
    a_in_valid  = v;
    a_in_result = r;
    a_in_flags  = f;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    a_drive(1'b1, 4'h7, 4'b0011);
    a_out_ready = 1'b0; a_clear = 1'b0;
    b_in_valid = 1'b0; b_in_result = 4'h0; b_in_flags = 4'h0;
    b_out_ready = 1'b1; b_clear = 1'b0;

    // T1: reset held two cycles with in_valid high
    @(negedge clk);
    step();
    check("t1_in_ready_in_rst", {31'd0, a_in_ready}, 32'd0);
    check("t1_out_valid", {31'd0, a_out_valid}, 32'd0);
    check("t1_out_result", {28'd0, a_out_result}, 32'd0);
    check("t1_sticky", {28'd0, a_sticky}, 32'd0);
    check("t1_count", {24'd0, a_count}, 32'd0);
    rst = 1'b0;
    a_drive(1'b0, 4'h0, 4'h0);
    step();
    check("t1_in_ready_after", {31'd0, a_in_ready}, 32'd1);
    check("t1_still_empty", {31'd0, a_out_valid}, 32'd0);

    // T2: single pass-through
    a_out_ready = 1'b1;
    a_drive(1'b1, 4'h5, 4'b0000);
    step();
    a_drive(1'b0, 4'h0, 4'h0);
    check("t2_out_valid", {31'd0, a_out_valid}, 32'd1);
    check("t2_out_result", {28'd0, a_out_result}, 32'h5);
    check("t2_out_flags", {28'd0, a_out_flags}, 32'h0);
    check("t2_count", {24'd0, a_count}, 32'd1);
    step();
    check("t2_drained", {31'd0, a_out_valid}, 32'd0);

    // T3: stall fills both entries, third push must wait
    a_out_ready = 1'b0;
    a_drive(1'b1, 4'h3, 4'b0000);
    step();
    a_drive(1'b1, 4'h0, 4'b0001);
    step();
    check("t3_full_in_ready", {31'd0, a_in_ready}, 32'd0);
    a_drive(1'b1, 4'h9, 4'b0000);
    step();
    check("t3_wait_in_ready", {31'd0, a_in_ready}, 32'd0);
    check("t3_head_stable", {28'd0, a_out_result}, 32'h3);
    check("t3_count_hold", {24'd0, a_count}, 32'd3);
    a_out_ready = 1'b1;
    step();
    check("t3_second_result", {28'd0, a_out_result}, 32'h0);
    check("t3_second_flags", {28'd0, a_out_flags}, 32'b0001);
    check("t3_reopen", {31'd0, a_in_ready}, 32'd1);
    step();
    a_drive(1'b0, 4'h0, 4'h0);
    check("t3_third_result", {28'd0, a_out_result}, 32'h9);
    check("t3_count", {24'd0, a_count}, 32'd4);
    check("t3_sticky", {28'd0, a_sticky}, 32'b0001);
    step();
    check("t3_drained", {31'd0, a_out_valid}, 32'd0);

    // T4: carry accumulation, reserved bits masked
    a_clear = 1'b1;
    step();
    a_clear = 1'b0;
    check("t4_clear_sticky", {28'd0, a_sticky}, 32'd0);
    check("t4_clear_count", {24'd0, a_count}, 32'd0);
    check("t4_data_kept", {28'd0, a_out_result}, 32'h9);
    a_drive(1'b1, 4'h2, 4'b0010);
    step();
    check("t4_first_flags", {28'd0, a_out_flags}, 32'b0010);
    a_drive(1'b1, 4'h0, 4'b1111);
    step();
    a_drive(1'b0, 4'h0, 4'h0);
    check("t4_second_result", {28'd0, a_out_result}, 32'h0);
    check("t4_second_flags", {28'd0, a_out_flags}, 32'b0011);
    check("t4_sticky", {28'd0, a_sticky}, 32'b0011);
    check("t4_count", {24'd0, a_count}, 32'd2);
    step();

    // T5: saturation and clear on the CW=2 instance
    b_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b_in_result = 4'(i + 1);
      step();
      if (i == 2) check("t5_count_at3", {30'd0, b_count}, 32'd3);
    end
    b_in_valid = 1'b0;
    check("t5_saturated", {30'd0, b_count}, 32'd3);
    check("t5_last_result", {28'd0, b_out_result}, 32'h5);
    b_clear = 1'b1;
    step();
    check("t5_clear_alone", {30'd0, b_count}, 32'd0);
    b_in_valid = 1'b1; b_in_flags = 4'b0001; b_in_result = 4'hA;
    step();
    b_clear = 1'b0; b_in_valid = 1'b0;
    check("t5_clear_push_count", {30'd0, b_count}, 32'd1);
    check("t5_clear_push_sticky", {28'd0, b_sticky}, 32'b0001);
    step();

    // T6: reset while both entries are occupied
    a_out_ready = 1'b0;
    a_drive(1'b1, 4'hA, 4'b0001);
    step();
    a_drive(1'b1, 4'hB, 4'b0010);
    step();
    check("t6_full", {31'd0, a_in_ready}, 32'd0);
    check("t6_head", {28'd0, a_out_result}, 32'hA);
    rst = 1'b1;
    a_drive(1'b1, 4'hC, 4'b0001);
    step();
    rst = 1'b0;
    check("t6_out_valid", {31'd0, a_out_valid}, 32'd0);
    check("t6_out_result", {28'd0, a_out_result}, 32'h0);
    check("t6_count", {24'd0, a_count}, 32'd0);
    a_out_ready = 1'b1;
    a_drive(1'b1, 4'h6, 4'b0010);
    step();
    a_drive(1'b0, 4'h0, 4'h0);
    check("t6_new_result", {28'd0, a_out_result}, 32'h6);
    check("t6_new_flags", {28'd0, a_out_flags}, 32'b0010);
    check("t6_new_count", {24'd0, a_count}, 32'd1);
    step();
    check("t6_drained", {31'd0, a_out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
